// File: rtl/shift_merge_sequencer.sv
// Sequencer and round-robin arbiter for the shared shift/merge unit.
// Owns the SAR, issues one registered operation at a time, returns the result tagged by requester.
module shift_merge_sequencer #(
   parameter logic [0:4] SAR_RST_VAL = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [0:31] req0_instr,
   input  logic [0:31] req0_a,
   input  logic [0:31] req0_b,
   input  logic        req0_use_sar,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [0:31] req1_instr,
   input  logic [0:31] req1_a,
   input  logic [0:31] req1_b,
   input  logic        req1_use_sar,
   input  logic        sar_wr_en,
   input  logic [0:4]  sar_wr_data,
   output logic [0:4]  sar,
   output logic [0:31] smu_instr,
   output logic [0:4]  smu_sa_reg,
   output logic [0:31] smu_a,
   output logic [0:31] smu_b,
   input  logic [0:31] smu_res,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [0:31] rsp_data
);

   typedef enum logic [1:0] {Idle, Exec, Resp} SeqState;

   SeqState     state;
   SeqState     nextState;
   logic        lastGrant;
   logic        grant0;
   logic        grant1;
   logic        accept;
   logic [0:31] issueInstr;
   logic [0:31] issueA;
   logic [0:31] issueB;
   logic [0:4]  issueSa;
   logic        issueId;
   logic        unusedUseSar;

   // The decode unit decides whether the SAR matters, so use_sar is carried but not acted on.
   assign unusedUseSar = req0_use_sar ^ req1_use_sar;

   // Round-robin: a lone requester always wins; on contention the port that did not win last time goes.
   assign grant0 = req0_valid & (~req1_valid | lastGrant);
   assign grant1 = req1_valid & (~req0_valid | ~lastGrant);
   assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign rsp_valid = (state == Resp);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= Idle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode plus the ready handshakes and the SMU drive, which is zero outside EXEC.
   always_comb begin
      nextState  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      smu_instr  = '0;
      smu_sa_reg = '0;
      smu_a      = '0;
      smu_b      = '0;
      case (state)
         Idle: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 | grant1) begin
               nextState = Exec;
            end
         end
         Exec: begin
            smu_instr  = issueInstr;
            smu_sa_reg = issueSa;
            smu_a      = issueA;
            smu_b      = issueB;
            nextState  = Resp;
         end
         Resp: begin
            if (rsp_ready) begin
               nextState = Idle;
            end
         end
         default: nextState = Idle;
      endcase
   end

   // The SAR takes writes in every state; in-flight operations keep their own latched copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sar <= SAR_RST_VAL;
      end else if (sar_wr_en) begin
         sar <= sar_wr_data;
      end
   end

   // Issue registers load on accept, with a same-cycle SAR write bypassing the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGrant  <= 1'b1;
         issueInstr <= '0;
         issueA     <= '0;
         issueB     <= '0;
         issueSa    <= '0;
         issueId    <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
      end else begin
         if (accept) begin
            lastGrant  <= req1_ready;
            issueId    <= req1_ready;
            issueInstr <= req1_ready ? req1_instr : req0_instr;
            issueA     <= req1_ready ? req1_a : req0_a;
            issueB     <= req1_ready ? req1_b : req0_b;
            issueSa    <= sar_wr_en ? sar_wr_data : sar;
         end
         if (state == Exec) begin
            rsp_data <= smu_res;
            rsp_id   <= issueId;
         end
      end
   end

endmodule

// File: doc/shift_merge_sequencer.md
# shift_merge_sequencer

Sequencer and arbiter for the shared shift/merge unit (SMU) and its decode logic. Two requesters compete for the unit: port 0 is the execute stage and port 1 is the microcode/diagnostic port. The block owns the shift-amount register (SAR) and presents one operation at a time to the SMU from registered operands. It returns the captured result over a valid/ready response channel tagged with the requester id.

## Interface
- SAR_RST_VAL, 5'd0, reset value of the SAR.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active high.
- req0_valid / req1_valid  in  1  request pending on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid and ready are both high.
- req0_instr / req1_instr  in  [0:31]  EXTR/DEP/DSR instruction word.
- req0_a, req0_b / req1_a, req1_b  in  [0:31]  source operands.
- req0_use_sar / req1_use_sar  in  1  the operation takes its shift amount from the SAR.
- sar_wr_en  in  1  SAR write strobe.
- sar_wr_data  in  [0:4]  SAR write value.
- sar  out  [0:4]  current SAR contents.
- smu_instr  out  [0:31]  instruction driven to the decode unit.
- smu_sa_reg  out  [0:4]  SAR value driven to the decode unit.
- smu_a / smu_b  out  [0:31]  operands driven to the SMU.
- smu_res  in  [0:31]  SMU result; combinational from the smu_* outputs.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester id of the response (0 or 1).
- rsp_data  out  [0:31]  captured result.

## Operation
- State machine with three states:
  - IDLE → EXEC on an accept.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when rsp_valid & rsp_ready.
  - Only one operation is outstanding at a time.
- Arbitration is round-robin with a 1-bit last-grant pointer, reset to 1 so port 0 wins first.
  - In IDLE, a sole valid port is granted.
  - If both ports are valid, the port not equal to the last grant wins.
  - The pointer updates on accept only.
- reqN_ready = (state==IDLE) & grantN. This is combinational from valids, pointer and state; the two ready signals are never both high.
- On accept, the block latches instr, a, b, the id, and the effective shift amount into issue registers.
- The effective shift amount is latched as-is; smu_sa_reg is driven for every operation. The decode unit ignores it when the instruction encodes an immediate amount, so use_sar is informational only.
- SAR bypass: if sar_wr_en is high in the accept cycle, the latched value is sar_wr_data, not the old sar.
- In EXEC, smu_instr, smu_sa_reg, smu_a and smu_b are driven from the issue registers. rsp_data <= smu_res at the end of EXEC.
- In IDLE and RESP, smu_instr/smu_a/smu_b/smu_sa_reg are driven to 0.
- SAR updates on any edge with sar_wr_en, in every state.
  - A write during EXEC/RESP does not affect the in-flight operation, which uses its latched value.
- rsp_valid is high exactly in RESP. rsp_id and rsp_data are stable while rsp_valid is high and rsp_ready is low.

## Timing
- Reset values: state=IDLE, sar=SAR_RST_VAL, pointer=1, rsp_valid=0, rsp_id=0, rsp_data=0, all smu_* outputs 0. req ready is combinational and high for the granted valid port right after reset.
- Accept at edge E0, then:
  - EXEC during cycle E0..E1.
  - rsp_valid rises after E1, so latency is 2 cycles from accept to response.
- Minimum issue interval is 3 cycles: the next accept is possible in the cycle after the response handshake edge.
- Backpressure: rsp_ready low holds RESP indefinitely, and both ready outputs stay low.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response, all registers return to their reset values, and the SAR is reset as well.
- Simultaneous SAR write and accept: the bypass rule applies, and sar shows the new value after the edge.
- Requester valid dropping before ready is not a protocol violation; nothing is latched.

## Test plan
- Single op: SAR write 5'd10, then req0 with instr 0x0000_1234, a=0xFFFF_0000, b=0x0000_FFFF, use_sar=1. Stub smu_res = smu_a ^ smu_b. Required: smu_sa_reg=10 in EXEC, rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0xFFFF_FFFF.
- Round-robin: req0 and req1 held valid for 4 ops. Required: grants in order 0,1,0,1, and each response id matches its grant.
- SAR bypass and isolation:
  - sar_wr_en with 5'd12 in the accept cycle → smu_sa_reg=12.
  - sar_wr_en with 5'd3 during EXEC → smu_sa_reg stays 12, and sar=3 afterwards.
- Backpressure: rsp_ready held low for 5 cycles. Required: rsp_valid, rsp_data and rsp_id stable, both ready outputs 0. Then rsp_ready=1 → IDLE on the next edge, and a new accept is possible the cycle after.
- Reset in EXEC: assert rst asynchronously mid-cycle. Required: rsp_valid=0 and sar=SAR_RST_VAL immediately, and no response follows. After deassert, req1 alone is granted.
- Idle outputs: with no requests, smu_* outputs remain 0 for 10 cycles.
